// File: rtl/uart_rx_deframe_pkg.sv
// Shared UART definitions: parity selection, frame bit positions and the receive FIFO entry.
package uart_rx_deframe_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_t;

    localparam int unsigned START_POS  = 0;
    localparam int unsigned DATA_LSB   = 1;
    localparam int unsigned DATA_MSB   = 8;
    localparam int unsigned PARITY_POS = 9;
    localparam int unsigned STOP_POS   = 10;
    localparam int unsigned FRAME_W    = 11;

    typedef struct packed {
        logic       stop_err;
        logic       parity_err;
        logic       start_err;
        logic [7:0] data;
    } rx_entry_t;

    // bits = {parity, data}; even parity expects an even count of ones across both
    function automatic logic parity_error(input parity_t ptype, input logic [8:0] bits);
        logic err;
        case (ptype)
            PAR_ODD:  err = ~(^bits);
            PAR_EVEN: err = ^bits;
            default:  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is taken only alongside a pop.
module uart_sync_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 11
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only visible through non-empty pointers.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_deframe.sv
// Checks start/parity/stop of a received UART frame and queues {errors, data} for the consumer.
module uart_rx_deframe #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_frame_valid,
    input  logic [10:0]             i_frame,
    input  logic [1:0]              i_parity_type,
    input  logic                    i_ready,
    input  logic                    i_clr_overrun,
    output logic                    o_valid,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_start_err,
    output logic                    o_parity_err,
    output logic                    o_stop_err,
    output logic                    o_overrun,
    output logic [$clog2(DEPTH):0]  o_count
);

    import uart_rx_deframe_pkg::*;

    rx_entry_t cap_d, cap_q;
    logic      cap_valid_q;
    rx_entry_t head;
    rx_entry_t head_vis;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop_fire;
    logic      drop;
    logic      overrun_d, overrun_q;

    always_comb begin
        cap_d            = '0;
        cap_d.data       = i_frame[DATA_MSB:DATA_LSB];
        cap_d.start_err  = i_frame[START_POS];
        cap_d.stop_err   = ~i_frame[STOP_POS];
        cap_d.parity_err = parity_error(parity_t'(i_parity_type),
                                        i_frame[PARITY_POS:DATA_LSB]);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cap_valid_q <= 1'b0;
            cap_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            cap_valid_q <= i_frame_valid;
            if (i_frame_valid) cap_q <= cap_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_sync_fifo #(
        .Depth (DEPTH),
        .Width ($bits(rx_entry_t))
    ) u_fifo (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .push_i   (cap_valid_q),
        .wdata_i  (cap_q),
        .pop_i    (i_ready),
        .rdata_o  (head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (o_count)
    );

    assign pop_fire = i_ready & ~fifo_empty;
    assign drop     = cap_valid_q & fifo_full & ~pop_fire;

    // A drop in the same cycle as a clear must remain visible.
    assign overrun_d = drop | (overrun_q & ~i_clr_overrun);

    assign head_vis     = fifo_empty ? '0 : head;
    assign o_valid      = ~fifo_empty;
    assign o_data       = head_vis.data;
    assign o_start_err  = head_vis.start_err;
    assign o_parity_err = head_vis.parity_err;
    assign o_stop_err   = head_vis.stop_err;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Directed bench for uart_rx_deframe: frame checks, latency, overrun, full-with-pop and reset.
module tb_uart_rx_deframe;

    logic        i_clk;
    logic        i_arst_n;
    logic        i_frame_valid;
    logic [10:0] i_frame;
    logic [1:0]  i_parity_type;
    logic        i_ready;
    logic        i_clr_overrun;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_start_err;
    logic        o_parity_err;
    logic        o_stop_err;
    logic        o_overrun;
    logic [2:0]  o_count;

    int checks = 0;
    int errors = 0;

    uart_rx_deframe #(
        .DEPTH (4)
    ) dut (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_frame_valid (i_frame_valid),
        .i_frame       (i_frame),
        .i_parity_type (i_parity_type),
        .i_ready       (i_ready),
        .i_clr_overrun (i_clr_overrun),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_start_err   (o_start_err),
        .o_parity_err  (o_parity_err),
        .o_stop_err    (o_stop_err),
        .o_overrun     (o_overrun),
        .o_count       (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [10:0] mk(input logic stop, input logic par, input logic [7:0] d,
                                       input logic start);
        return {stop, par, d, start};
    endfunction

    // Well-formed frame carrying correct even parity.
    function automatic logic [10:0] good(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [10:0] f, input logic [1:0] pt);
        i_frame_valid = 1'b1;
        i_frame       = f;
        i_parity_type = pt;
        tick();
        i_frame_valid = 1'b0;
    endtask

    task automatic pop1();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] d, input logic se,
                              input logic pe, input logic ste);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_data"}, 32'(o_data), 32'(d));
        chk({tag, "_start"}, 32'(o_start_err), 32'(se));
        chk({tag, "_parity"}, 32'(o_parity_err), 32'(pe));
        chk({tag, "_stop"}, 32'(o_stop_err), 32'(ste));
    endtask

    initial begin
        i_arst_n      = 1'b0;
        i_frame_valid = 1'b0;
        i_frame       = '0;
        i_parity_type = 2'b00;
        i_ready       = 1'b0;
        i_clr_overrun = 1'b0;
        #12;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        chk("rst_data", 32'(o_data), 32'h00);
        chk("rst_errs", 32'({o_start_err, o_parity_err, o_stop_err}), 32'd0);
        tick();
        i_arst_n = 1'b1;
        tick();

        // Clean frame, even parity, latency 2.
        send(11'b1_0_10100101_0, 2'b10);
        chk("lat_n1_valid", 32'(o_valid), 32'd0);
        tick();
        check_head("even", 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("even_count", 32'(o_count), 32'd1);
        pop1();
        chk("pop_valid", 32'(o_valid), 32'd0);
        chk("pop_count", 32'(o_count), 32'd0);

        send(11'b1_0_10100101_0, 2'b01);
        tick();
        check_head("odd", 8'hA5, 1'b0, 1'b1, 1'b0);
        pop1();

        send(mk(1'b1, 1'b0, 8'hA5, 1'b1), 2'b10);
        tick();
        check_head("start", 8'hA5, 1'b1, 1'b0, 1'b0);
        pop1();

        send(mk(1'b0, 1'b0, 8'hA5, 1'b0), 2'b10);
        tick();
        check_head("stop", 8'hA5, 1'b0, 1'b0, 1'b1);
        pop1();

        send(mk(1'b1, 1'b1, 8'hA5, 1'b0), 2'b00);
        tick();
        check_head("none", 8'hA5, 1'b0, 1'b0, 1'b0);
        pop1();

        send(mk(1'b1, 1'b1, 8'hA5, 1'b0), 2'b11);
        tick();
        check_head("none2", 8'hA5, 1'b0, 1'b0, 1'b0);
        pop1();

        // Five back-to-back strobes into a depth-4 FIFO: the fifth is dropped.
        for (int i = 1; i <= 5; i++) send(good(8'(i)), 2'b10);
        tick();
        chk("ovr_count", 32'(o_count), 32'd4);
        chk("ovr_flag", 32'(o_overrun), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check_head($sformatf("drain%0d", i), 8'(i), 1'b0, 1'b0, 1'b0);
            pop1();
        end
        chk("drain_empty", 32'(o_valid), 32'd0);
        i_clr_overrun = 1'b1;
        tick();
        i_clr_overrun = 1'b0;
        chk("clr_alone", 32'(o_overrun), 32'd0);

        // Full FIFO, pop in the push cycle: entry accepted, no overrun.
        for (int i = 0; i < 4; i++) send(good(8'h10 + 8'(i)), 2'b10);
        tick();
        chk("full_count", 32'(o_count), 32'd4);
        send(good(8'h14), 2'b10);
        pop1();
        chk("fp_count", 32'(o_count), 32'd4);
        chk("fp_overrun", 32'(o_overrun), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check_head($sformatf("fp%0d", i), 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
            pop1();
        end

        // Drop coinciding with clear: set wins.
        for (int i = 0; i < 5; i++) send(good(8'h20 + 8'(i)), 2'b10);
        tick();
        chk("ovr2_flag", 32'(o_overrun), 32'd1);
        send(good(8'h25), 2'b10);
        i_clr_overrun = 1'b1;
        tick();
        i_clr_overrun = 1'b0;
        chk("set_wins", 32'(o_overrun), 32'd1);
        chk("set_wins_count", 32'(o_count), 32'd4);
        check_head("set_wins_head", 8'h20, 1'b0, 1'b0, 1'b0);
        pop1();
        chk("pre_rst_count", 32'(o_count), 32'd3);

        // Reset with 3 entries queued and a frame in the pipeline.
        send(good(8'h77), 2'b10);
        i_arst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_count", 32'(o_count), 32'd0);
        chk("mrst_overrun", 32'(o_overrun), 32'd0);
        tick();
        i_arst_n = 1'b1;
        tick();
        chk("mrst_inflight", 32'(o_valid), 32'd0);
        send(good(8'h3C), 2'b10);
        chk("post_n1_valid", 32'(o_valid), 32'd0);
        tick();
        check_head("post", 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("post_count", 32'(o_count), 32'd1);
        pop1();
        chk("post_empty", 32'(o_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframe.md
Name: uart_rx_deframe

Overview:
- Consumes the 11-bit parallel frame and one-cycle received strobe produced by the UART receiver's serial-to-parallel stage.
- Checks start, parity and stop bits, and extracts the 8 data bits.
- Pushes {error flags, data} into a small synchronous FIFO.
- Presents FIFO entries on a valid/ready interface to the bus/register side.
- Runs on the same sampling clock as the serial-to-parallel stage.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DATA_W, 8, data bits per frame; fixed by the frame format, not to be overridden.

Ports:
- i_clk  in  1  sampling clock, shared with the serial-to-parallel stage
- i_arst_n  in  1  asynchronous active-low reset
- i_frame_valid  in  1  one-cycle strobe: i_frame is complete
- i_frame  in  11  frame, LSB = first bit received: [0] start, [8:1] data (LSB first), [9] parity, [10] stop
- i_parity_type  in  2  00 none, 01 odd, 10 even, 11 none
- i_ready  in  1  consumer accepts the head entry
- i_clr_overrun  in  1  clears o_overrun
- o_valid  out  1  FIFO not empty
- o_data  out  8  head entry data
- o_start_err  out  1  head entry: start bit was 1
- o_parity_err  out  1  head entry: parity mismatch
- o_stop_err  out  1  head entry: stop bit was 0
- o_overrun  out  1  sticky: a frame was dropped
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, i_arst_n low):
  - Pipeline register cleared, FIFO pointers 0, o_count 0, o_valid 0, o_overrun 0.
  - o_data 8'h00 and all error outputs 0.
  - A reset mid-operation discards every pending entry and any frame in flight.
- Stage 1 (capture), on the cycle i_frame_valid is high:
  - Register data = i_frame[8:1].
  - start_err = i_frame[0].
  - stop_err = ~i_frame[10].
  - parity_err:
    - even: ^i_frame[9:1] != 0
    - odd: ^i_frame[9:1] != 1
    - none: 0, and i_frame[9] is ignored.
  - i_parity_type is sampled in the same cycle as i_frame_valid.
- Stage 2 (push): the cycle after capture, the 11-bit entry {stop_err, parity_err, start_err, data} is pushed.
- Latency: strobe at cycle N → entry written at the N+1 edge → o_valid high in cycle N+2 if the FIFO was empty.
- Back-to-back strobes on consecutive cycles are each captured; the pipeline holds one frame.
- Pop occurs when o_valid && i_ready. The outputs show the head entry combinationally from FIFO storage.
- While o_valid=0, the output fields are don't-care. Bench checks them only when o_valid=1.
- Full FIFO:
  - A push is accepted if count < DEPTH, or if a pop occurs in the same cycle. Simultaneous push and pop leaves count unchanged.
  - Otherwise the entry is dropped, FIFO contents are unchanged, and o_overrun is set at the next edge.
- Empty FIFO: i_ready with o_valid=0 has no effect, and the pointers do not move.
- Pointers are $clog2(DEPTH)+1 bits. Wrap-around uses the MSB to distinguish full from empty.
  - full = (wr_ptr ^ rd_ptr) == {1'b1, 0...}
  - o_count = wr_ptr - rd_ptr, modulo width.
- o_overrun: sticky. If set and i_clr_overrun occur in the same cycle, set wins.
- Frames with errors are still stored. Error handling is the consumer's responsibility.

Decomposition:
- Shared UART package holds:
  - typedef parity_t, an enum of 2 bits: PAR_NONE=00, PAR_ODD=01, PAR_EVEN=10, PAR_NONE2=11.
  - Frame bit-position constants: START_POS=0, DATA_LSB=1, DATA_MSB=8, PARITY_POS=9, STOP_POS=10, FRAME_W=11.
  - typedef rx_entry_t, a packed struct {stop_err, parity_err, start_err, data[7:0]}.
- One sub-module, uart_sync_fifo, parameterised by DEPTH and entry width, with push/pop/full/empty/count.
  - It is reusable by the transmit path.
  - Deframe check logic and the overrun flag stay in the top block.

Test Plan:
- Frame 11'b1_0_10100101_0, even parity, one strobe → cycle N+2: o_valid=1, o_data=8'hA5, all three errors 0; pop with i_ready=1 → o_valid=0, o_count=0.
- Same frame with odd parity selected → o_parity_err=1, data 8'hA5. Frame with i_frame[0]=1 → o_start_err=1. Frame with i_frame[10]=0 → o_stop_err=1. Parity type none with bit 9 wrong → o_parity_err=0.
- i_ready=0, 5 strobes of data 01..05 with DEPTH=4 → o_count=4, o_overrun=1. Drain yields 01,02,03,04 in order; 05 is lost.
- FIFO full, strobe in cycle K and pop in cycle K+1 (the push cycle) → no overrun, o_count stays 4, new entry appears last.
- o_overrun set; assert i_clr_overrun in the same cycle as an overrun drop → o_overrun stays 1. Clear alone → o_overrun=0.
- 3 entries queued, assert i_arst_n=0 for one cycle → o_valid=0, o_count=0, o_overrun=0. A new frame afterwards emerges with latency 2.
